// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the program counter, issues fetch requests to a 1-cycle-latency
// fetcher and presents fetched instructions with their PCs to decode through
// a registered output stage backed by a 1-entry skid buffer. It absorbs
// decode stalls, applies branch redirects with a flush, and halts for good on
// an illegal branch target or after the last word of code memory drains.
//
// Ports
//   clk, nreset        rising-edge clock, asynchronous active-low reset
//   fetch_enable       request a fetch of fetch_pc this cycle
//   fetch_pc           byte address to fetch (always 4-aligned)
//   fetch_ready        fetcher response valid, cycle after an enabled request
//   fetch_inst         fetched word, valid with fetch_ready
//   stall              decode cannot accept; out_* hold
//   branch_valid       single-cycle redirect request
//   branch_target      redirect byte address
//   out_valid          out_inst/out_pc hold a live instruction
//   out_inst, out_pc   instruction to decode and its byte address
//   halted             sticky halt indicator
//   dbg_state          current FSM state (IDLE=0, RUN=1, STALLED=2, HALTED=3)
//
// Handshake: a fetch request is the single cycle fetch_enable=1; its response
// is the cycle fetch_ready=1 that follows, honoured only while a request is
// in flight. Decode takes out_* on every clock edge where out_valid=1 and
// stall=0; while stall=1 out_* do not change.
module fetch_sequencer #(
  parameter int BIT_WIDTH  = 32,
  parameter int INST_COUNT = 64
) (
  input  logic                 clk,
  input  logic                 nreset,
  output logic                 fetch_enable,
  output logic [BIT_WIDTH-1:0] fetch_pc,
  input  logic                 fetch_ready,
  input  logic [BIT_WIDTH-1:0] fetch_inst,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic [BIT_WIDTH-1:0] branch_target,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_inst,
  output logic [BIT_WIDTH-1:0] out_pc,
  output logic                 halted,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STALLED = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  localparam logic [BIT_WIDTH-1:0] PC_LIMIT = BIT_WIDTH'(4 * INST_COUNT);
  localparam logic [BIT_WIDTH-1:0] PC_STEP  = BIT_WIDTH'(4);

  state_t               state;
  state_t               state_nxt;
  logic [BIT_WIDTH-1:0] pc;
  logic                 inflight;
  logic [BIT_WIDTH-1:0] inflight_pc;
  logic                 skid_valid;
  logic [BIT_WIDTH-1:0] skid_inst;
  logic [BIT_WIDTH-1:0] skid_pc;

  logic active;
  logic redirect;
  logic resp;
  logic pc_legal;
  logic target_bad;
  logic drain_done;

  assign active     = (state == S_RUN) || (state == S_STALLED);
  assign redirect   = branch_valid && (state != S_HALTED);
  assign resp       = inflight && fetch_ready;
  assign pc_legal   = (pc < PC_LIMIT);
  assign target_bad = (branch_target[1:0] != 2'b00) || (branch_target >= PC_LIMIT);
  // Past the last word with nothing in flight and nothing parked.
  assign drain_done = !pc_legal && !inflight && !skid_valid;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (branch_valid) state_nxt = target_bad ? S_HALTED : S_RUN;
        else              state_nxt = S_RUN;
      end
      S_RUN, S_STALLED: begin
        if (branch_valid)    state_nxt = target_bad ? S_HALTED : S_RUN;
        else if (stall)      state_nxt = S_STALLED;
        else if (drain_done) state_nxt = S_HALTED;
        else                 state_nxt = S_RUN;
      end
      default: state_nxt = S_HALTED;
    endcase
  end

  // Output logic
  always_comb begin
    fetch_enable = 1'b0;
    if (active && !branch_valid && !stall && !skid_valid && pc_legal)
      fetch_enable = 1'b1;
  end

  assign fetch_pc  = pc;
  assign halted    = (state == S_HALTED);
  assign dbg_state = state;

  // Datapath: PC, in-flight tracking, skid buffer and output stage.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_inst   <= '0;
      skid_pc     <= '0;
      out_valid   <= 1'b0;
      out_inst    <= '0;
      out_pc      <= '0;
    end else if (redirect) begin
      // Flush: the response still due next cycle is dropped via inflight=0.
      pc         <= branch_target;
      inflight   <= 1'b0;
      skid_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else if (active) begin
      if (fetch_enable) begin
        pc          <= pc + PC_STEP;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else if (resp) begin
        inflight <= 1'b0;
      end

      if (stall) begin
        // Only one request can be outstanding, so the skid never overflows.
        if (resp) begin
          skid_valid <= 1'b1;
          skid_inst  <= fetch_inst;
          skid_pc    <= inflight_pc;
        end
      end else if (skid_valid) begin
        out_valid  <= 1'b1;
        out_inst   <= skid_inst;
        out_pc     <= skid_pc;
        skid_valid <= 1'b0;
      end else if (resp) begin
        out_valid <= 1'b1;
        out_inst  <= fetch_inst;
        out_pc    <= inflight_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer. Code memory word i holds the value i, so every
// out_inst must equal out_pc/4. A queue-based model of the sequencer is
// compared against the DUT on every falling edge; directed checks taken 2 ns
// after rising edges pin the model with hand-computed values.
module tb_fetch_sequencer;

  localparam int W     = 32;
  localparam int NINST = 64;
  localparam logic [W-1:0] LIMIT = W'(4 * NINST);

  // Clock / reset
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic         fetch_enable;
  logic [W-1:0] fetch_pc;
  logic         fetch_ready = 1'b0;
  logic [W-1:0] fetch_inst = '0;
  logic         stall = 1'b0;
  logic         branch_valid = 1'b0;
  logic [W-1:0] branch_target = '0;
  logic         out_valid;
  logic [W-1:0] out_inst;
  logic [W-1:0] out_pc;
  logic         halted;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.BIT_WIDTH(W), .INST_COUNT(NINST)) dut (
    .clk(clk), .nreset(nreset),
    .fetch_enable(fetch_enable), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .fetch_inst(fetch_inst),
    .stall(stall), .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .halted(halted), .dbg_state(dbg_state)
  );

  // Fetcher: answers every request one cycle later with word index pc/4.
  always @(posedge clk) begin
    fetch_ready <= fetch_enable;
    fetch_inst  <= fetch_pc >> 2;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: requests in flight and the parked instruction are kept as queues
  // of PCs; the fetcher always answers one cycle after a request.
  logic         m_started, m_halted, m_out_valid;
  logic [W-1:0] m_pc, m_out_pc;
  logic [W-1:0] m_req[$];
  logic [W-1:0] exp_q[$];   // instruction parked while decode stalls

  function automatic logic model_fe();
    return m_started && !m_halted && !branch_valid && !stall &&
           (exp_q.size() == 0) && (m_pc < LIMIT);
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_halted = 1'b0; m_out_valid = 1'b0;
    m_pc = '0; m_out_pc = '0;
    m_req.delete(); exp_q.delete();
  endtask

  task automatic model_step();
    logic         fe, had_resp, done;
    logic [W-1:0] rpc;
    fe = model_fe();
    if (m_halted) begin
    end else if (branch_valid) begin
      m_started = 1'b1;
      m_out_valid = 1'b0;
      m_req.delete(); exp_q.delete();
      m_pc = branch_target;
      if (branch_target[1:0] != 2'b00 || branch_target >= LIMIT) m_halted = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else begin
      had_resp = (m_req.size() != 0);
      rpc = had_resp ? m_req.pop_front() : '0;
      done = !stall && (m_pc >= LIMIT) && !had_resp && (exp_q.size() == 0);
      if (fe) begin
        m_req.push_back(m_pc);
        m_pc = m_pc + 4;
      end
      if (stall) begin
        if (had_resp) exp_q.push_back(rpc);
      end else if (exp_q.size() != 0) begin
        m_out_pc = exp_q.pop_front();
        m_out_valid = 1'b1;
      end else if (had_resp) begin
        m_out_pc = rpc;
        m_out_valid = 1'b1;
      end else begin
        m_out_valid = 1'b0;
      end
      if (done) m_halted = 1'b1;
    end
  endtask

  // Scoreboard: compare, then advance the model with the inputs that the
  // coming rising edge will sample (inputs only change 2 ns after an edge).
  always @(negedge clk) begin
    if (!nreset) begin
      model_reset();
    end else begin
      check("model fetch_enable", {31'b0, fetch_enable}, {31'b0, model_fe()});
      check("model fetch_pc", fetch_pc, m_pc);
      check("model out_valid", {31'b0, out_valid}, {31'b0, m_out_valid});
      if (m_out_valid) begin
        check("model out_pc", out_pc, m_out_pc);
        check("model out_inst", out_inst, m_out_pc >> 2);
      end
      check("model halted", {31'b0, halted}, {31'b0, m_halted});
      model_step();
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_branch(input logic [W-1:0] tgt);
    branch_valid = 1'b1;
    branch_target = tgt;
    tick();
    branch_valid = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic next_valid(input string name, input logic [W-1:0] exp, input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!out_valid && k < budget);
    check({name, " valid"}, {31'b0, out_valid}, 32'd1);
    check({name, " pc"}, out_pc, exp);
    check({name, " inst"}, out_inst, exp >> 2);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " fetch_enable"}, {31'b0, fetch_enable}, 32'd0);
    check({name, " fetch_pc"}, fetch_pc, 32'd0);
    check({name, " out_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, " out_inst"}, out_inst, 32'd0);
    check({name, " out_pc"}, out_pc, 32'd0);
    check({name, " halted"}, {31'b0, halted}, 32'd0);
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check_reset_outputs("reset");
    nreset = 1'b1;

    // Start-up timing
    tick();  // E0
    check("E0 fetch_enable", {31'b0, fetch_enable}, 32'd1);
    check("E0 fetch_pc", fetch_pc, 32'd0);
    tick();  // E1
    check("E1 fetch_pc", fetch_pc, 32'd4);
    check("E1 out_valid", {31'b0, out_valid}, 32'd0);
    tick();  // E2
    check("E2 out_valid", {31'b0, out_valid}, 32'd1);
    check("E2 out_pc", out_pc, 32'd0);
    check("E2 out_inst", out_inst, 32'd0);
    tick();
    check("E3 out_pc", out_pc, 32'd4);
    tick();
    check("E4 out_pc", out_pc, 32'd8);

    // Stall for three cycles while out_pc=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall hold pc", out_pc, 32'd8);
      check("stall hold valid", {31'b0, out_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check("release out_pc", out_pc, 32'd12);
    check("release out_valid", {31'b0, out_valid}, 32'd1);
    next_valid("after release", 32'h10, 4);

    // Branch while 0x14 is in flight
    pulse_branch(32'h40);
    check("branch bubble1", {31'b0, out_valid}, 32'd0);
    tick();
    check("branch bubble2", {31'b0, out_valid}, 32'd0);
    tick();
    check("branch target valid", {31'b0, out_valid}, 32'd1);
    check("branch target pc", out_pc, 32'h40);
    tick();
    check("branch next pc", out_pc, 32'h44);

    // Branch together with stall and a full skid
    stall = 1'b1;
    tick();
    pulse_branch(32'h80);
    stall = 1'b0;
    check("stall branch bubble1", {31'b0, out_valid}, 32'd0);
    tick();
    check("stall branch bubble2", {31'b0, out_valid}, 32'd0);
    tick();
    check("stall branch pc", out_pc, 32'h80);
    check("stall branch valid", {31'b0, out_valid}, 32'd1);

    // Misaligned target halts; later branches are ignored
    pulse_branch(32'h42);
    check("misaligned halted", {31'b0, halted}, 32'd1);
    check("misaligned fetch_enable", {31'b0, fetch_enable}, 32'd0);
    check("misaligned out_valid", {31'b0, out_valid}, 32'd0);
    pulse_branch(32'h0);
    for (int i = 0; i < 3; i++) begin
      check("halt ignores branch", {31'b0, halted}, 32'd1);
      check("halt fetch_enable", {31'b0, fetch_enable}, 32'd0);
      tick();
    end

    // Out-of-range target halts
    do_reset();
    tick();
    tick();
    pulse_branch(LIMIT);
    check("range halted", {31'b0, halted}, 32'd1);
    check("range fetch_enable", {31'b0, fetch_enable}, 32'd0);

    // Sequential run through all of code memory
    do_reset();
    for (int i = 0; i < NINST; i++) next_valid("seq", W'(4 * i), 4);
    check("seq last not halted yet", {31'b0, halted}, 32'd0);
    tick();
    check("seq end halted", {31'b0, halted}, 32'd1);
    check("seq end out_valid", {31'b0, out_valid}, 32'd0);
    check("seq end fetch_enable", {31'b0, fetch_enable}, 32'd0);

    // Asynchronous reset in the middle of a stall
    do_reset();
    repeat (5) tick();
    stall = 1'b1;
    tick();
    tick();
    #1;
    nreset = 1'b0;
    #1;
    check_reset_outputs("async reset");
    stall = 1'b0;
    tick();
    nreset = 1'b1;
    next_valid("post reset", 32'd0, 4);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
